// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed, big-endian data memory controller with a
// valid/ready request channel, a valid/ready response channel, configurable
// access latency, load sign/zero extension and alignment/range error reporting.
// One request is outstanding at a time.
// Optional feature: define DMEM_CTRL_STATS_EN to add the stat_loads,
// stat_stores and stat_errors handshake counters.
module dmem_ctrl #(
    parameter int SIZE    = 32768,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [0:AW-1] req_addr,
    input  logic [0:31]   req_wdata,
    input  logic [0:1]    req_dsize,
    input  logic          req_signed,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [0:31]   resp_rdata,
    output logic          resp_err
`ifdef DMEM_CTRL_STATS_EN
    ,
    output logic [0:31]   stat_loads,
    output logic [0:31]   stat_stores,
    output logic [0:31]   stat_errors
`endif
);

    localparam int IW = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_write;
    logic          lat_signed;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [1:0]    lat_dsize;

    logic [7:0]    mem [0:SIZE-1];

    logic          accept;
    logic          do_access;
    logic          acc_write;
    logic          acc_signed;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [1:0]    acc_dsize;
    logic [2:0]    nbytes_m1;
    logic [AW:0]   last_addr;
    logic          acc_err;
    logic [IW-1:0] i0, i1, i2, i3;
    logic [7:0]    rb0, rb1, rb2, rb3;
    logic [31:0]   ld_data;

    assign accept = (state == IDLE) && req_valid && !rst;

    // The access uses the live request when it happens on the accept edge
    // (single-cycle latency), otherwise the fields latched at accept.
    always_comb begin
        if (state == IDLE) begin
            acc_write  = req_write;
            acc_signed = req_signed;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_dsize  = req_dsize;
        end else begin
            acc_write  = lat_write;
            acc_signed = lat_signed;
            acc_addr   = lat_addr;
            acc_wdata  = lat_wdata;
            acc_dsize  = lat_dsize;
        end
    end

    assign do_access = !rst && (((LATENCY == 1) && accept) ||
                                ((state == WAIT) && (cnt == 4'd0)));

    // Access legality: size code, natural alignment and end-of-array range.
    always_comb begin
        case (acc_dsize)
            2'd3:    nbytes_m1 = 3'd3;
            2'd1:    nbytes_m1 = 3'd1;
            default: nbytes_m1 = 3'd0;
        endcase
        last_addr = {1'b0, acc_addr} + {{(AW-2){1'b0}}, nbytes_m1};
        acc_err   = (acc_dsize == 2'd2) ||
                    ((acc_dsize == 2'd1) && acc_addr[0]) ||
                    ((acc_dsize == 2'd3) && (acc_addr[1:0] != 2'd0)) ||
                    (last_addr >= (AW+1)'(SIZE));
    end

    assign i0 = acc_addr[IW-1:0];
    assign i1 = i0 + IW'(1);
    assign i2 = i0 + IW'(2);
    assign i3 = i0 + IW'(3);

    assign rb0 = mem[i0];
    assign rb1 = mem[i1];
    assign rb2 = mem[i2];
    assign rb3 = mem[i3];

    // Load result: big-endian assembly, right-justified and extended.
    always_comb begin
        case (acc_dsize)
            2'd3:    ld_data = {rb0, rb1, rb2, rb3};
            2'd1:    ld_data = {{16{rb0[7] & acc_signed}}, rb0, rb1};
            default: ld_data = {{24{rb0[7] & acc_signed}}, rb0};
        endcase
        if (acc_err || acc_write) begin
            ld_data = 32'd0;
        end
    end

    // Store path: array is not reset, writes only on a legal store access.
    always_ff @(posedge clk) begin
        if (do_access && acc_write && !acc_err) begin
            case (acc_dsize)
                2'd3: begin
                    mem[i0] <= acc_wdata[31:24];
                    mem[i1] <= acc_wdata[23:16];
                    mem[i2] <= acc_wdata[15:8];
                    mem[i3] <= acc_wdata[7:0];
                end
                2'd1: begin
                    mem[i0] <= acc_wdata[15:8];
                    mem[i1] <= acc_wdata[7:0];
                end
                default: begin
                    mem[i0] <= acc_wdata[7:0];
                end
            endcase
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            lat_dsize  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write  <= req_write;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_dsize  <= req_dsize;
                        cnt        <= 4'(LATENCY - 1);
                        req_ready  <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= ld_data;
                            resp_err   <= acc_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_data;
                        resp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMEM_CTRL_STATS_EN
    // Completed response handshakes by kind; errors counted only as errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads  <= 32'd0;
            stat_stores <= 32'd0;
            stat_errors <= 32'd0;
        end else if (resp_valid && resp_ready) begin
            if (resp_err) begin
                stat_errors <= stat_errors + 32'd1;
            end else if (lat_write) begin
                stat_stores <= stat_stores + 32'd1;
            end else begin
                stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed transactions checked against a byte-array
// model of the memory plus literal expectations, with a per-cycle monitor of
// the handshake and response outputs.
module tb_dmem_ctrl;

    localparam int SIZE = 32768;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [0:31] req_addr = 32'd0;
    logic [0:31] req_wdata = 32'd0;
    logic [0:1]  req_dsize = 2'd0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [0:31] resp_rdata;
    logic        resp_err;
`ifdef DMEM_CTRL_STATS_EN
    logic [0:31] stat_loads, stat_stores, stat_errors;
`endif

    dmem_ctrl #(.SIZE(SIZE), .LATENCY(LAT), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_dsize  (req_dsize),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
`ifdef DMEM_CTRL_STATS_EN
        ,
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  mm [int];
    bit          outstanding = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_rdata = 32'd0;
    bit          exp_err = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic int nbytes(input int ds);
        return (ds == 3) ? 4 : (ds == 1) ? 2 : 1;
    endfunction

    // Expected response from the rules: size/alignment/range legality and a
    // big-endian read of the model byte array with optional sign extension.
    function automatic void model(input bit w, input int a, input int ds, input bit sg,
                                  output bit e, output logic [31:0] d);
        int n;
        n = nbytes(ds);
        e = (ds == 2) || (a % n != 0) || (a + n > SIZE);
        d = 32'd0;
        if (!e && !w) begin
            for (int i = 0; i < n; i++) d = (d << 8) | {24'd0, mm[a + i]};
            if (sg && n < 4 && d[8*n-1]) d = d | (32'hFFFF_FFFF << (8 * n));
        end
    endfunction

    task automatic model_write(input int a, input int ds, input logic [31:0] wd);
        int n;
        n = nbytes(ds);
        for (int i = 0; i < n; i++) mm[a + i] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    always @(posedge clk) cyc++;

    // Per-cycle monitor: handshake readiness, response timing and contents.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                chk("rst_req_ready", 32'(req_ready), 32'd1);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                chk("rst_rdata", resp_rdata, 32'd0);
                chk("rst_err", 32'(resp_err), 32'd0);
            end else begin
                bit ev;
                ev = outstanding && ((cyc - acc_cyc) >= LAT);
                chk("mon_req_ready", 32'(req_ready), 32'(!outstanding));
                chk("mon_resp_valid", 32'(resp_valid), 32'(ev));
                if (ev) begin
                    chk("mon_rdata", resp_rdata, exp_rdata);
                    chk("mon_err", 32'(resp_err), 32'(exp_err));
                end
            end
        end
    end

    // One request/response transaction; hold = cycles resp_ready is withheld.
    task automatic txn(input string name, input bit w, input int a, input int ds,
                       input bit sg, input logic [31:0] wd, input int hold,
                       output logic [31:0] got_d, output bit got_e);
        bit e;
        logic [31:0] d;
        int n;
        model(w, a, ds, sg, e, d);
        got_d = 32'hxxxx_xxxx;
        got_e = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_dsize = 2'(ds);
        req_signed = sg; req_wdata = wd;
        @(posedge clk); #1;
        outstanding = 1'b1; acc_cyc = cyc; exp_rdata = d; exp_err = e;
        req_valid = 1'b0; req_write = ~w; req_addr = 32'h0000_0004;
        req_wdata = 32'hFFFF_FFFF; req_dsize = 2'd3; req_signed = ~sg;
        for (n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (resp_valid) break;
        end
        if (n == 20) begin
            chk({name, "_timeout"}, 32'd20, 32'd0);
            outstanding = 1'b0;
            return;
        end
        chk({name, "_latency"}, 32'(n + 1), 32'(LAT));
        got_d = resp_rdata;
        got_e = resp_err;
        repeat (hold) begin
            @(posedge clk); #1;
            chk({name, "_hold_rdata"}, resp_rdata, got_d);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        outstanding = 1'b0;
        if (w && !e) model_write(a, ds, wd);
        $display("txn %-10s w=%0d addr=0x%05h ds=%0d sg=%0d wd=0x%08h -> rdata=0x%08h err=%0d",
                 name, w, a, ds, sg, wd, got_d, got_e);
    endtask

    logic [31:0] rd;
    bit          er;

    initial begin
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        txn("st_200", 1, 32'h200, 3, 0, 32'hCAFE_F00D, 0, rd, er);
        chk("st_200_err", 32'(er), 32'd0);
        chk("st_200_rd", rd, 32'd0);

        // Store then immediately load the same word
        txn("st_100", 1, 32'h100, 3, 0, 32'hDEAD_BEEF, 0, rd, er);
        chk("st_100_err", 32'(er), 32'd0);
        txn("ld_100", 0, 32'h100, 3, 0, 32'h0, 0, rd, er);
        chk("ld_100_rd", rd, 32'hDEAD_BEEF);
        chk("ld_100_err", 32'(er), 32'd0);

        // Sub-word loads with extension
        txn("lb_101_s", 0, 32'h101, 0, 1, 32'h0, 0, rd, er);
        chk("lb_101_s_rd", rd, 32'hFFFF_FFAD);
        txn("lb_101_u", 0, 32'h101, 0, 0, 32'h0, 0, rd, er);
        chk("lb_101_u_rd", rd, 32'h0000_00AD);
        txn("lh_102_s", 0, 32'h102, 1, 1, 32'h0, 0, rd, er);
        chk("lh_102_s_rd", rd, 32'hFFFF_BEEF);
        txn("lh_102_u", 0, 32'h102, 1, 0, 32'h0, 0, rd, er);
        chk("lh_102_u_rd", rd, 32'h0000_BEEF);
        txn("lb_100_u", 0, 32'h100, 0, 0, 32'h0, 0, rd, er);
        chk("lb_100_u_rd", rd, 32'h0000_00DE);

        // Error cases
        txn("lw_102", 0, 32'h102, 3, 0, 32'h0, 0, rd, er);
        chk("lw_102_err", 32'(er), 32'd1);
        chk("lw_102_rd", rd, 32'd0);
        txn("sh_103", 1, 32'h103, 1, 0, 32'h1234, 0, rd, er);
        chk("sh_103_err", 32'(er), 32'd1);
        txn("ld_100b", 0, 32'h100, 3, 0, 32'h0, 0, rd, er);
        chk("ld_100b_rd", rd, 32'hDEAD_BEEF);
        txn("ds2", 0, 32'h100, 2, 0, 32'h0, 0, rd, er);
        chk("ds2_err", 32'(er), 32'd1);
        chk("ds2_rd", rd, 32'd0);

        // Top-of-array boundary
        txn("lw_top", 0, SIZE - 2, 3, 0, 32'h0, 0, rd, er);
        chk("lw_top_err", 32'(er), 32'd1);
        txn("lh_top", 0, SIZE - 1, 1, 0, 32'h0, 0, rd, er);
        chk("lh_top_err", 32'(er), 32'd1);
        txn("sb_last", 1, SIZE - 1, 0, 0, 32'h0000_005A, 0, rd, er);
        chk("sb_last_err", 32'(er), 32'd0);
        txn("lb_last", 0, SIZE - 1, 0, 0, 32'h0, 0, rd, er);
        chk("lb_last_rd", rd, 32'h0000_005A);
        chk("lb_last_err", 32'(er), 32'd0);

        // Halfword store writes only the low 16 bits of wdata
        txn("sh_104", 1, 32'h104, 1, 0, 32'hA5A5_8001, 0, rd, er);
        txn("lh_104_u", 0, 32'h104, 1, 0, 32'h0, 0, rd, er);
        chk("lh_104_u_rd", rd, 32'h0000_8001);
        txn("lh_104_s", 0, 32'h104, 1, 1, 32'h0, 0, rd, er);
        chk("lh_104_s_rd", rd, 32'hFFFF_8001);

        // Consumer back-pressure for 5 cycles
        txn("ld_hold", 0, 32'h100, 3, 0, 32'h0, 5, rd, er);
        chk("ld_hold_rd", rd, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("hold_idle_ready", 32'(req_ready), 32'd1);

        // Reset one cycle after accepting a store aborts it
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200;
        req_dsize = 2'd3; req_signed = 1'b0; req_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        outstanding = 1'b1; acc_cyc = cyc; exp_rdata = 32'd0; exp_err = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        outstanding = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        $display("txn %-10s store 0x11223344 @0x200 aborted by reset", "abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        txn("ld_200", 0, 32'h200, 3, 0, 32'h0, 0, rd, er);
        chk("ld_200_rd", rd, 32'hCAFE_F00D);
        chk("ld_200_err", 32'(er), 32'd0);

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
